// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: sequencer for the breakout core on the development board.
//
// Debounces the four active-low board buttons. Runs the game state machine
// (idle, serve, play, pause, game over) and counts lives from the core's
// end-of-ball level. Drives the core reset, run enable, gated left/right
// controls and the status LEDs.
//
// Optional feature macro: GAME_PAUSE_EN
//   defined   - PAUSE state and the B5 pause debouncer are built; led[1] shows PAUSE.
//   undefined - no PAUSE state, btn_pause_n is ignored, led[1] is tied to 0.
//
// Ports:
//   clk           in   50 MHz system clock
//   rst_n         in   asynchronous active-low reset (synchronous release expected)
//   btn_left_n    in   B2, active-low, asynchronous to clk
//   btn_right_n   in   B3, active-low, asynchronous to clk
//   btn_start_n   in   B4, active-low, asynchronous to clk
//   btn_pause_n   in   B5, active-low, asynchronous to clk
//   core_end      in   core end-of-ball level, synchronous to clk
//   core_rst_n    out  active-low reset to the game core
//   core_run      out  core advance enable
//   core_left_n   out  gated left control, active-low
//   core_right_n  out  gated right control, active-low
//   state         out  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4
//   lives         out  remaining lives
//   led           out  [0]=PLAY, [1]=PAUSE, [2]=OVER, [4:3]=lives
//
// Every output is driven straight from a flop.

module game_flow_ctrl #(
    parameter int unsigned DB_CYCLES        = 500000,
    parameter int unsigned LIVES            = 3,
    parameter int unsigned SERVE_CYCLES     = 16,
    parameter int unsigned OVER_LOCK_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    input  logic       btn_start_n,
    input  logic       btn_pause_n,
    input  logic       core_end,
    output logic       core_rst_n,
    output logic       core_run,
    output logic       core_left_n,
    output logic       core_right_n,
    output logic [2:0] state,
    output logic [1:0] lives,
    output logic [4:0] led
);

`ifdef GAME_PAUSE_EN
    localparam int unsigned NumBtn = 4;
`else
    localparam int unsigned NumBtn = 3;
`endif
    localparam int unsigned BtnLeft  = 0;
    localparam int unsigned BtnRight = 1;
    localparam int unsigned BtnStart = 2;
`ifdef GAME_PAUSE_EN
    localparam int unsigned BtnPause = 3;
`endif

    // Debounce and lock counters share one width, wide enough for either limit.
    localparam int unsigned CntMax = (DB_CYCLES > OVER_LOCK_CYCLES) ? DB_CYCLES
                                                                    : OVER_LOCK_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned ServeW = $clog2(SERVE_CYCLES + 1);

    localparam logic [CntW-1:0]   DbLast    = CntW'(DB_CYCLES - 1);
    localparam logic [CntW-1:0]   LockMax   = CntW'(OVER_LOCK_CYCLES);
    localparam logic [ServeW-1:0] ServeLast = ServeW'(SERVE_CYCLES - 1);
    localparam logic [1:0]        LivesInit = 2'(LIVES);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StPause = 3'd3,
        StOver  = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Button debouncers
    // ------------------------------------------------------------------
    logic [NumBtn-1:0] btn_raw;

`ifdef GAME_PAUSE_EN
    assign btn_raw = {btn_pause_n, btn_start_n, btn_right_n, btn_left_n};
`else
    assign btn_raw = {btn_start_n, btn_right_n, btn_left_n};
    logic unused_pause;
    assign unused_pause = btn_pause_n;
`endif

    logic [NumBtn-1:0] sync1_q, sync2_q;
    logic [NumBtn-1:0] db_q, db_d;
    logic [NumBtn-1:0] db_dly_q;
    logic [NumBtn-1:0] press_q, press_d;
    logic [CntW-1:0]   db_cnt_q [NumBtn];
    logic [CntW-1:0]   db_cnt_d [NumBtn];

    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NumBtn; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbLast) begin
                // This cycle is the DB_CYCLES-th consecutive mismatch: accept it.
                db_d[i]     = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + CntW'(1);
            end
        end
        // Press = debounced level seen going 1->0 (one cycle after the flip).
        press_d = db_dly_q & ~db_q;
    end

    logic start_press;
    assign start_press = press_q[BtnStart];
`ifdef GAME_PAUSE_EN
    logic pause_press;
    assign pause_press = press_q[BtnPause];
`endif

    // ------------------------------------------------------------------
    // core_end rising edge
    // ------------------------------------------------------------------
    logic end_prev_q;
    logic end_edge;
    assign end_edge = core_end & ~end_prev_q;

    // ------------------------------------------------------------------
    // Game state machine
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [1:0]        lives_q, lives_d;
    logic [ServeW-1:0] serve_q, serve_d;
    logic [CntW-1:0]   lock_q, lock_d;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        serve_d = serve_q;
        lock_d  = lock_q;

        // The lock counter only runs in OVER, so it starts from zero on every entry.
        if (state_q != StOver) begin
            lock_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                serve_d = '0;
                if (start_press) begin
                    state_d = StServe;
                    lives_d = LivesInit;
                end
            end
            StServe: begin
                if (serve_q == ServeLast) begin
                    state_d = StPlay;
                    serve_d = '0;
                end else begin
                    serve_d = serve_q + ServeW'(1);
                end
            end
            StPlay: begin
                if (end_edge) begin
                    serve_d = '0;
                    if (lives_q == 2'd1) begin
                        state_d = StOver;
                        lives_d = 2'd0;
                    end else begin
                        state_d = StServe;
                        lives_d = lives_q - 2'd1;
                    end
`ifdef GAME_PAUSE_EN
                end else if (pause_press) begin
                    state_d = StPause;
`endif
                end
            end
`ifdef GAME_PAUSE_EN
            StPause: begin
                if (start_press) begin
                    state_d = StIdle;
                    lives_d = 2'd0;
                end else if (pause_press) begin
                    state_d = StPlay;
                end
            end
`endif
            StOver: begin
                if (lock_q == LockMax) begin
                    // Presses before saturation are simply dropped.
                    if (start_press) begin
                        state_d = StServe;
                        lives_d = LivesInit;
                        serve_d = '0;
                        lock_d  = '0;
                    end
                end else begin
                    lock_d = lock_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                lives_d = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, computed from the next state so they line up with it
    // ------------------------------------------------------------------
    logic       core_rst_n_q, core_rst_n_d;
    logic       core_run_q, core_run_d;
    logic       core_left_n_q, core_left_n_d;
    logic       core_right_n_q, core_right_n_d;
    logic [4:0] led_q, led_d;
    logic       pause_led;

    always_comb begin
`ifdef GAME_PAUSE_EN
        pause_led = (state_d == StPause);
`else
        pause_led = 1'b0;
`endif
        core_rst_n_d   = (state_d != StIdle) && (state_d != StServe);
        core_run_d     = (state_d == StPlay);
        core_left_n_d  = (state_d == StPlay) ? db_q[BtnLeft]  : 1'b1;
        core_right_n_d = (state_d == StPlay) ? db_q[BtnRight] : 1'b1;
        led_d          = {lives_d, (state_d == StOver), pause_led, (state_d == StPlay)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q        <= '1;
            sync2_q        <= '1;
            db_q           <= '1;
            db_dly_q       <= '1;
            press_q        <= '0;
            for (int i = 0; i < NumBtn; i++) begin
                db_cnt_q[i] <= '0;
            end
            end_prev_q     <= 1'b0;
            state_q        <= StIdle;
            lives_q        <= 2'd0;
            serve_q        <= '0;
            lock_q         <= '0;
            core_rst_n_q   <= 1'b0;
            core_run_q     <= 1'b0;
            core_left_n_q  <= 1'b1;
            core_right_n_q <= 1'b1;
            led_q          <= 5'd0;
        end else begin
            sync1_q        <= btn_raw;
            sync2_q        <= sync1_q;
            db_q           <= db_d;
            db_dly_q       <= db_q;
            press_q        <= press_d;
            db_cnt_q       <= db_cnt_d;
            end_prev_q     <= core_end;
            state_q        <= state_d;
            lives_q        <= lives_d;
            serve_q        <= serve_d;
            lock_q         <= lock_d;
            core_rst_n_q   <= core_rst_n_d;
            core_run_q     <= core_run_d;
            core_left_n_q  <= core_left_n_d;
            core_right_n_q <= core_right_n_d;
            led_q          <= led_d;
        end
    end

    assign core_rst_n   = core_rst_n_q;
    assign core_run     = core_run_q;
    assign core_left_n  = core_left_n_q;
    assign core_right_n = core_right_n_q;
    assign state        = state_q;
    assign lives        = lives_q;
    assign led          = led_q;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Sequences the breakout game core on the development board.
- Debounces the four active-low board buttons (B2 left, B3 right, B4 start, B5 pause).
- Runs the game state machine: idle, serve, play, pause, game over. Counts lives from the core's end-of-ball signal.
- Drives the core's reset, run enable and gated left/right controls, plus status LEDs.
- Sits between the board pins and the breakout core, inside the board top.

Parameters:
- DB_CYCLES, 500000: stable cycles required to accept a button level change (10 ms at 50 MHz).
- LIVES, 3: lives loaded at game start; legal range 1..3.
- SERVE_CYCLES, 16: cycles core_rst_n is held low in SERVE.
- OVER_LOCK_CYCLES, 25000000: cycles in OVER during which start is ignored.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- btn_left_n  in  1  B2, active-low, asynchronous to clk
- btn_right_n  in  1  B3, active-low, asynchronous
- btn_start_n  in  1  B4, active-low, asynchronous
- btn_pause_n  in  1  B5, active-low, asynchronous
- core_end  in  1  core end-of-ball level, synchronous to clk
- core_rst_n  out  1  active-low reset to game core
- core_run  out  1  core advance enable
- core_left_n  out  1  gated left control, active-low
- core_right_n  out  1  gated right control, active-low
- state  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4
- lives  out  2  remaining lives
- led  out  5  [0]=PLAY, [1]=PAUSE, [2]=OVER, [4:3]=lives

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE, lives=0, core_rst_n=0, core_run=0, core_left_n=1, core_right_n=1, led=0.
  - All debounced levels=1; all counters=0.
- Debounce, per button:
  - 2-FF synchroniser feeds a counter of cycles where the synced value differs from the debounced value. Counter clears on match.
  - When the count reaches DB_CYCLES the debounced value flips and the counter clears.
  - A press is a 1-cycle registered pulse, issued on a debounced 1->0 flip.
  - Total latency: the state register changes on the DB_CYCLES+4th rising edge after the first edge that samples the new stable level.
  - Glitches shorter than DB_CYCLES produce no event.
- core_end rising edge: registered previous value; edge = core_end & ~prev. prev updates every cycle in every state.
- IDLE:
  - core_rst_n=0, core_run=0.
  - start press -> SERVE; lives:=LIVES; serve counter cleared.
- SERVE:
  - core_rst_n=0, core_run=0.
  - Counter increments each cycle; at SERVE_CYCLES-1 -> PLAY (core_rst_n low for exactly SERVE_CYCLES cycles).
  - All buttons are ignored.
- PLAY:
  - core_rst_n=1, core_run=1; core_left_n/core_right_n = debounced levels.
  - core_end edge: if lives==1 -> OVER with lives:=0; else lives:=lives-1 -> SERVE.
  - Else pause press -> PAUSE.
  - core_end edge wins over a simultaneous pause press.
- PAUSE:
  - core_rst_n=1, core_run=0, core_left_n=core_right_n=1.
  - core_end edges are ignored and do not decrement lives.
  - pause press -> PLAY. start press -> IDLE, lives:=0. Simultaneous start and pause presses: start wins.
- OVER:
  - core_rst_n=1 (final screen kept), core_run=0, controls forced 1.
  - Lock counter saturates at OVER_LOCK_CYCLES.
  - start press with counter saturated -> SERVE, lives:=LIVES, lock counter cleared. Earlier presses are discarded, not queued.
- Outputs in all states:
  - core_left_n/core_right_n are 1 in every state except PLAY.
  - All outputs are registered: no combinational path from any input to any output.
- Widths:
  - lives is 2-bit.
  - Counters are sized to hold their parameter value (DB, lock: 25 bits by default; serve: 5 bits).
- Mid-operation reset: rst_n low in any state returns all reset values immediately, without waiting for a clock.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined: PAUSE state and btn_pause_n behave as above; led[1] reflects PAUSE.
- Undefined: no PAUSE state or pause debouncer is built; btn_pause_n is ignored; led[1]=0 constant.

Test Plan:
Bench parameters: DB_CYCLES=4, LIVES=3, SERVE_CYCLES=8, OVER_LOCK_CYCLES=20.
1. Reset, hold start low 10 cycles:
   - state=SERVE on the 8th edge after the first low sample; lives=3.
   - core_rst_n low exactly 8 cycles; then state=PLAY, core_run=1.
2. In PLAY, pulse btn_start_n low for 3 cycles: no press event, state stays PLAY.
3. In PLAY, three core_end 0->1 edges, each after returning to PLAY:
   - lives goes 3->2->1, SERVE after the first two edges.
   - Third edge: state=OVER, lives=0, led=5'b00100.
4. In OVER, press start 10 cycles after entry: ignored. Press again after 20 cycles: SERVE, lives=3.
5. With GAME_PAUSE_EN:
   - In PLAY, press pause: PAUSE, core_run=0, core_left_n=1 while B2 held low.
   - core_end edge in PAUSE: lives unchanged.
   - Press pause again: PLAY.
6. Assert rst_n low mid-SERVE:
   - Outputs reach reset values before the next clk edge.
   - After release: state=IDLE, lives=0.
